// File: rtl/text_scan_gen.sv
// text_scan_gen: raster timing plus text-cell scan coordinates.
// Every output is registered from next-state counter values, so all
// outputs describe the same (o_hcount, o_vcount) in the same cycle.
module text_scan_gen #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int HSZ          = 10,
  parameter int VSZ          = 10,
  parameter int GLYPH_W      = 8,
  parameter int GLYPH_H      = 8,
  parameter int COL_W        = 7,
  parameter int ROW_W        = 6,
  parameter bit SYNC_POL     = 1'b0,
  parameter int BLINK_FRAMES = 30,
  localparam int CXW = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1,
  localparam int GRW = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_scroll_we,
  input  logic [ROW_W-1:0] i_scroll_row,
  output logic [HSZ-1:0]   o_hcount,
  output logic [VSZ-1:0]   o_vcount,
  output logic             o_de,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic [CXW-1:0]   o_cell_x,
  output logic [GRW-1:0]   o_glyph_row,
  output logic [COL_W-1:0] o_text_col,
  output logic [ROW_W-1:0] o_text_row,
  output logic             o_line_start,
  output logic             o_frame_start,
  output logic             o_blink
);

  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int TEXT_COLS = H_ACTIVE / GLYPH_W;
  localparam int TEXT_ROWS = V_ACTIVE / GLYPH_H;
  localparam int BCW       = $clog2(BLINK_FRAMES + 1);

  localparam logic [HSZ-1:0]   H_LAST  = HSZ'(H_TOTAL - 1);
  localparam logic [VSZ-1:0]   V_LAST  = VSZ'(V_TOTAL - 1);
  localparam logic [HSZ-1:0]   H_ACT   = HSZ'(H_ACTIVE);
  localparam logic [VSZ-1:0]   V_ACT   = VSZ'(V_ACTIVE);
  localparam logic [HSZ-1:0]   HS_BEG  = HSZ'(H_ACTIVE + H_FP);
  localparam logic [HSZ-1:0]   HS_END  = HSZ'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VSZ-1:0]   VS_BEG  = VSZ'(V_ACTIVE + V_FP);
  localparam logic [VSZ-1:0]   VS_END  = VSZ'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CXW-1:0]   CX_LAST = CXW'(GLYPH_W - 1);
  localparam logic [GRW-1:0]   GR_LAST = GRW'(GLYPH_H - 1);
  localparam logic [ROW_W:0]   TR_C    = (ROW_W+1)'(TEXT_ROWS);
  localparam logic [BCW-1:0]   BF_LAST = BCW'(BLINK_FRAMES - 1);

  // Parameter sanity: refuse to elaborate configurations the counters cannot represent.
  if ((H_ACTIVE % GLYPH_W) != 0 || (V_ACTIVE % GLYPH_H) != 0) begin : g_bad_glyph
    $error("text_scan_gen: active size not a multiple of glyph size");
  end
  if (H_BP == 0 || V_BP == 0) begin : g_bad_bp
    $error("text_scan_gen: back porch must be non-zero");
  end
  if (H_TOTAL > (1 << HSZ) || V_TOTAL > (1 << VSZ)) begin : g_bad_cnt
    $error("text_scan_gen: counter width too small for total size");
  end
  if (TEXT_COLS > (1 << COL_W) || TEXT_ROWS > (1 << ROW_W)) begin : g_bad_text
    $error("text_scan_gen: text column/row width too small");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink
    $error("text_scan_gen: BLINK_FRAMES must be at least 1");
  end

  logic [HSZ-1:0]   r_hcount, w_h_nxt;
  logic [VSZ-1:0]   r_vcount, w_v_nxt;
  logic             r_de, r_hsync, r_vsync, r_line_start, r_frame_start, r_blink;
  logic [CXW-1:0]   r_cell_x, w_cx_nxt;
  logic [COL_W-1:0] r_text_col, w_col_nxt;
  logic [GRW-1:0]   r_glyph_row, w_gr_nxt;
  logic [ROW_W-1:0] r_raw_row, w_raw_nxt;
  logic [ROW_W-1:0] r_text_row, w_tr_nxt;
  logic [ROW_W-1:0] r_pend, r_scroll, w_scr_nxt;
  logic [BCW-1:0]   r_fcnt;
  logic             w_hwrap, w_h_act, w_v_act, w_frame, w_hs_act, w_vs_act;
  logic [ROW_W:0]   w_sum;

  // Next raster position and the decode derived from it.
  always_comb begin
    w_hwrap  = (r_hcount == H_LAST);
    w_h_nxt  = w_hwrap ? '0 : r_hcount + 1'b1;
    w_v_nxt  = r_vcount;
    if (w_hwrap) w_v_nxt = (r_vcount == V_LAST) ? '0 : r_vcount + 1'b1;
    w_h_act  = (w_h_nxt < H_ACT);
    w_v_act  = (w_v_nxt < V_ACT);
    w_frame  = (w_h_nxt == '0) && (w_v_nxt == '0);
    w_hs_act = (w_h_nxt >= HS_BEG) && (w_h_nxt < HS_END);
    w_vs_act = (w_v_nxt >= VS_BEG) && (w_v_nxt < VS_END);
  end

  // Horizontal cell counters step with the pixel; cleared outside the active width.
  always_comb begin
    w_cx_nxt  = '0;
    w_col_nxt = '0;
    if (w_h_act && w_h_nxt != '0) begin
      if (r_cell_x == CX_LAST) begin
        w_col_nxt = r_text_col + 1'b1;
      end else begin
        w_cx_nxt  = r_cell_x + 1'b1;
        w_col_nxt = r_text_col;
      end
    end
  end

  // Vertical cell counters step only at a line wrap; cleared in vertical blanking.
  always_comb begin
    w_gr_nxt  = r_glyph_row;
    w_raw_nxt = r_raw_row;
    if (!w_v_act) begin
      w_gr_nxt  = '0;
      w_raw_nxt = '0;
    end else if (w_hwrap) begin
      if (w_v_nxt == '0) begin
        w_gr_nxt  = '0;
        w_raw_nxt = '0;
      end else if (r_glyph_row == GR_LAST) begin
        w_gr_nxt  = '0;
        w_raw_nxt = r_raw_row + 1'b1;
      end else begin
        w_gr_nxt  = r_glyph_row + 1'b1;
      end
    end
  end

  // Scrolled row: the frame-start edge already sees the newly latched scroll value.
  always_comb begin
    w_scr_nxt = w_frame ? r_pend : r_scroll;
    w_sum     = {1'b0, w_raw_nxt} + {1'b0, w_scr_nxt};
    if (w_sum >= TR_C) w_sum = w_sum - TR_C;
    w_tr_nxt  = w_v_act ? w_sum[ROW_W-1:0] : '0;
  end

  // All registered state: counters, decoded outputs, scroll and blink.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hcount      <= H_LAST;
      r_vcount      <= V_LAST;
      r_de          <= 1'b0;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_cell_x      <= '0;
      r_text_col    <= '0;
      r_glyph_row   <= '0;
      r_raw_row     <= '0;
      r_text_row    <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_blink       <= 1'b0;
      r_pend        <= '0;
      r_scroll      <= '0;
      r_fcnt        <= '0;
    end else begin
      r_hcount      <= w_h_nxt;
      r_vcount      <= w_v_nxt;
      r_de          <= w_h_act && w_v_act;
      r_hsync       <= w_hs_act ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= w_vs_act ? SYNC_POL : ~SYNC_POL;
      r_cell_x      <= w_cx_nxt;
      r_text_col    <= w_col_nxt;
      r_glyph_row   <= w_gr_nxt;
      r_raw_row     <= w_raw_nxt;
      r_text_row    <= w_tr_nxt;
      r_line_start  <= (w_h_nxt == '0);
      r_frame_start <= w_frame;
      r_scroll      <= w_scr_nxt;
      if (i_scroll_we && ({1'b0, i_scroll_row} < TR_C)) r_pend <= i_scroll_row;
      if (w_frame) begin
        if (r_fcnt == BF_LAST) begin
          r_fcnt  <= '0;
          r_blink <= ~r_blink;
        end else begin
          r_fcnt  <= r_fcnt + 1'b1;
        end
      end
    end
  end

  assign o_hcount      = r_hcount;
  assign o_vcount      = r_vcount;
  assign o_de          = r_de;
  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_cell_x      = r_cell_x;
  assign o_text_col    = r_text_col;
  assign o_glyph_row   = r_glyph_row;
  assign o_text_row    = r_text_row;
  assign o_line_start  = r_line_start;
  assign o_frame_start = r_frame_start;
  assign o_blink       = r_blink;

endmodule

// File: tb/tb_text_scan_gen.sv
// Bench for text_scan_gen on a reduced raster (48x27 total, 32x20 active,
// 4x2 glyphs) so several frames fit in a short run.
module tb_text_scan_gen;

  localparam int HA = 32, HFP = 4, HSY = 6, HBP = 6;
  localparam int VA = 20, VFP = 2, VSY = 2, VBP = 3;
  localparam int GW = 4, GH = 2, BF = 2;
  localparam int HT = HA + HFP + HSY + HBP;   // 48
  localparam int VT = VA + VFP + VSY + VBP;   // 27
  localparam int TR = VA / GH;                // 10

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       we  = 1'b0;
  logic [5:0] srow = '0;
  logic [9:0] hcount, vcount;
  logic       de, hsync, vsync, ls, fs, blink;
  logic [1:0] cell_x;
  logic [0:0] glyph_row;
  logic [6:0] text_col;
  logic [5:0] text_row;

  text_scan_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HSZ(10), .VSZ(10), .GLYPH_W(GW), .GLYPH_H(GH),
    .COL_W(7), .ROW_W(6), .SYNC_POL(1'b0), .BLINK_FRAMES(BF)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_scroll_we(we), .i_scroll_row(srow),
    .o_hcount(hcount), .o_vcount(vcount), .o_de(de),
    .o_hsync(hsync), .o_vsync(vsync), .o_cell_x(cell_x),
    .o_glyph_row(glyph_row), .o_text_col(text_col), .o_text_row(text_row),
    .o_line_start(ls), .o_frame_start(fs), .o_blink(blink)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] h; logic [9:0] v;
    logic de; logic hs; logic vs;
    logic [1:0] cx; logic [6:0] col; logic [0:0] gr; logic [5:0] tr;
    logic ls; logic fs; logic bl;
  } obs_t;

  typedef struct {
    int h; int v;
    int cx; int col; int gr; int tr;
    bit de; bit hs; bit vs; bit ls;
  } vec_t;

  int tests = 0, fails = 0;
  obs_t sbq[$];

  // reference model state (position reached after the last edge)
  int mh, mv, mpend, mscr, mfcnt;
  bit mblink;

  // frame-level measurements taken from the DUT outputs
  int cyc = 0, last_fs = 0, de_acc = 0, fs_n = 0;
  bit fs_seen = 0;

  function automatic obs_t sample();
    obs_t o;
    o = '{h: hcount, v: vcount, de: de, hs: hsync, vs: vsync, cx: cell_x,
          col: text_col, gr: glyph_row, tr: text_row, ls: ls, fs: fs, bl: blink};
    return o;
  endfunction

  // One clock: drive inputs, push model expectation, compare after the edge.
  task automatic step(input logic r, input logic w, input logic [5:0] row);
    obs_t e, got, x;
    bit frame;
    rst = r; we = w; srow = row;
    if (r) begin
      mh = HT - 1; mv = VT - 1; mpend = 0; mscr = 0; mfcnt = 0; mblink = 0;
      e = '{h: 10'(HT-1), v: 10'(VT-1), de: 0, hs: 1, vs: 1, cx: 0, col: 0,
            gr: 0, tr: 0, ls: 0, fs: 0, bl: 0};
    end else begin
      if (mh == HT - 1) begin mh = 0; mv = (mv == VT - 1) ? 0 : mv + 1; end
      else mh = mh + 1;
      frame = (mh == 0) && (mv == 0);
      if (frame) begin
        mscr = mpend;
        mfcnt = mfcnt + 1;
        if (mfcnt == BF) begin mfcnt = 0; mblink = ~mblink; end
      end
      if (w && row < TR) mpend = row;
      e.h  = 10'(mh); e.v = 10'(mv);
      e.de = (mh < HA) && (mv < VA);
      e.hs = !(mh >= HA + HFP && mh < HA + HFP + HSY);
      e.vs = !(mv >= VA + VFP && mv < VA + VFP + VSY);
      e.cx  = (mh < HA) ? 2'(mh % GW) : '0;
      e.col = (mh < HA) ? 7'(mh / GW) : '0;
      e.gr  = (mv < VA) ? 1'(mv % GH) : '0;
      e.tr  = (mv < VA) ? 6'((mv / GH + mscr) % TR) : '0;
      e.ls = (mh == 0); e.fs = frame; e.bl = mblink;
    end
    sbq.push_back(e);
    @(posedge clk); #1;
    cyc++;
    got = sample();
    x = sbq.pop_front();
    tests++;
    if (got !== x) begin
      fails++;
      $display("FAIL scoreboard cyc=%0d got=%h expected=%h", cyc, got, x);
    end
    if (r) begin
      fs_seen = 0; fs_n = 0;
    end else begin
      if (fs) begin
        fs_n++;
        tests++;
        if (blink !== ((fs_n / 2) % 2 == 1)) begin
          fails++;
          $display("FAIL blink_phase fs#%0d got=%0b", fs_n, blink);
        end
        if (fs_seen) begin
          tests++;
          if (cyc - last_fs != HT * VT || de_acc != HA * VA) begin
            fails++;
            $display("FAIL frame_len interval=%0d need=%0d de=%0d need=%0d",
                     cyc - last_fs, HT * VT, de_acc, HA * VA);
          end
        end
        fs_seen = 1; last_fs = cyc; de_acc = 0;
      end
      if (de) de_acc++;
    end
    rst = 1'b0; we = 1'b0;
  endtask

  // Advance until the model position is (h,v); bounded.
  task automatic goto(input int h, input int v);
    int n = 0;
    while (!(mh == h && mv == v) && n < 3000) begin
      step(0, 0, '0);
      n++;
    end
    if (n >= 3000) begin
      tests++; fails++;
      $display("FAIL goto_timeout target=(%0d,%0d) at=(%0d,%0d)", h, v, mh, mv);
    end
  endtask

  task automatic chk_tr(input string name, input int need);
    tests++;
    if (text_row !== 6'(need)) begin
      fails++;
      $display("FAIL %s text_row=%0d need=%0d", name, text_row, need);
    end
  endtask

  task automatic chk_reset(input string name);
    tests++;
    if (hcount !== 10'(HT-1) || vcount !== 10'(VT-1) || de !== 0 || hsync !== 1 ||
        vsync !== 1 || cell_x !== 0 || text_col !== 0 || glyph_row !== 0 ||
        text_row !== 0 || ls !== 0 || fs !== 0 || blink !== 0) begin
      fails++;
      $display("FAIL %s got h=%0d v=%0d de=%0b hs=%0b vs=%0b bl=%0b", name,
               hcount, vcount, de, hsync, vsync, blink);
    end
  endtask

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{h:0,  v:0,  cx:0, col:0, gr:0, tr:0, de:1, hs:1, vs:1, ls:1};
    tbl[1]  = '{h:0,  v:1,  cx:0, col:0, gr:1, tr:0, de:1, hs:1, vs:1, ls:1};
    tbl[2]  = '{h:17, v:5,  cx:1, col:4, gr:1, tr:2, de:1, hs:1, vs:1, ls:0};
    tbl[3]  = '{h:31, v:19, cx:3, col:7, gr:1, tr:9, de:1, hs:1, vs:1, ls:0};
    tbl[4]  = '{h:32, v:19, cx:0, col:0, gr:1, tr:9, de:0, hs:1, vs:1, ls:0};
    tbl[5]  = '{h:35, v:19, cx:0, col:0, gr:1, tr:9, de:0, hs:1, vs:1, ls:0};
    tbl[6]  = '{h:36, v:19, cx:0, col:0, gr:1, tr:9, de:0, hs:0, vs:1, ls:0};
    tbl[7]  = '{h:41, v:19, cx:0, col:0, gr:1, tr:9, de:0, hs:0, vs:1, ls:0};
    tbl[8]  = '{h:42, v:19, cx:0, col:0, gr:1, tr:9, de:0, hs:1, vs:1, ls:0};
    tbl[9]  = '{h:0,  v:22, cx:0, col:0, gr:0, tr:0, de:0, hs:1, vs:0, ls:1};
    tbl[10] = '{h:47, v:23, cx:0, col:0, gr:0, tr:0, de:0, hs:1, vs:0, ls:0};

    // reset state
    step(1, 0, '0);
    step(1, 0, '0);
    chk_reset("reset_state");

    // first edge out of reset lands on (0,0)
    step(0, 0, '0);
    tests++;
    if (hcount !== 0 || vcount !== 0 || de !== 1 || fs !== 1 || ls !== 1) begin
      fails++;
      $display("FAIL first_pixel h=%0d v=%0d de=%0b fs=%0b ls=%0b", hcount, vcount, de, fs, ls);
    end

    // table of raster positions within frame 0 (scroll 0)
    for (int i = 0; i < 11; i++) begin
      goto(tbl[i].h, tbl[i].v);
      tests++;
      if (hcount !== 10'(tbl[i].h) || vcount !== 10'(tbl[i].v) ||
          cell_x !== 2'(tbl[i].cx) || text_col !== 7'(tbl[i].col) ||
          glyph_row !== 1'(tbl[i].gr) || text_row !== 6'(tbl[i].tr) ||
          de !== tbl[i].de || hsync !== tbl[i].hs || vsync !== tbl[i].vs ||
          ls !== tbl[i].ls) begin
        fails++;
        $display("FAIL vec%0d (%0d,%0d) cx=%0d col=%0d gr=%0d tr=%0d de=%0b hs=%0b vs=%0b ls=%0b",
                 i, hcount, vcount, cell_x, text_col, glyph_row, text_row, de, hsync, vsync, ls);
      end
    end

    // scroll write mid-frame: no effect until the next frame start
    goto(0, 0);
    goto(10, 3);
    step(0, 1, 6'd8);
    chk_tr("scroll_pending_same_line", 1);
    goto(5, 4);
    chk_tr("scroll_pending_later_line", 2);
    goto(5, 0);
    chk_tr("scroll_applied_line0", 8);
    goto(5, 4);
    chk_tr("scroll_wrap_line4", 0);

    // out-of-range write is dropped
    step(0, 1, 6'd10);
    goto(5, 0);
    chk_tr("scroll_oob_ignored", 8);

    // write on the (0,0) edge: old pending used this frame, new value next frame
    goto(HT - 1, VT - 1);
    step(0, 1, 6'd3);
    chk_tr("scroll_edge_old", 8);
    goto(HT - 1, VT - 1);
    step(0, 0, '0);
    chk_tr("scroll_edge_new", 3);

    // mid-frame reset drops pending scroll and blink phase
    goto(10, 10);
    step(0, 1, 6'd5);
    goto(20, 10);
    step(1, 0, '0);
    chk_reset("mid_reset");
    step(0, 0, '0);
    tests++;
    if (hcount !== 0 || vcount !== 0 || fs !== 1 || blink !== 0 || text_row !== 0) begin
      fails++;
      $display("FAIL after_mid_reset h=%0d v=%0d fs=%0b bl=%0b tr=%0d", hcount, vcount, fs, blink, text_row);
    end
    goto(HT - 1, VT - 1);
    step(0, 0, '0);
    chk_tr("pending_lost", 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
